// File: rtl/add7_pkg.sv
// Shared definitions for the 7-bit slice sequencer: slice width, the
// sequencer state type and the slice overflow helper.
package add7_pkg;

    localparam int SLICE_W = 7;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } seq_state_t;

    // Signed overflow of a slice: carry into the MSB differs from carry out of it.
    function automatic logic slice_ovf(input logic c6, input logic c5);
        return c6 ^ c5;
    endfunction

endpackage

// File: rtl/add7_slice.sv
// Combinational 7-bit ripple-carry adder built from a chain of 1-bit full
// adders; every per-bit carry-out is exposed so the caller can derive overflow.
module add7_slice
    import add7_pkg::*;
(
    input  logic [SLICE_W-1:0] a,
    input  logic [SLICE_W-1:0] b,
    input  logic               c_in,
    output logic [SLICE_W-1:0] s,
    output logic [SLICE_W-1:0] c
);

    logic carry;

    always_comb begin
        carry = c_in;
        s     = '0;
        c     = '0;
        for (int i = 0; i < SLICE_W; i++) begin
            s[i]  = a[i] ^ b[i] ^ carry;
            c[i]  = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
            carry = c[i];
        end
    end

endmodule

// File: rtl/add7_slice_sequencer.sv
// Wide add/subtract computed one 7-bit slice per cycle through a single shared
// ripple slice, LSB slice first, with valid/ready handshakes on both sides.
module add7_slice_sequencer
    import add7_pkg::*;
#(
    parameter  int SLICES = 4,
    localparam int WIDTH  = SLICE_W * SLICES
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             out_ovf,
    output logic             busy
);

    localparam int IDX_W = $clog2(SLICES + 1);

    seq_state_t         state_q;
    logic [IDX_W-1:0]   idx_q;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;
    logic [WIDTH-1:0]   sum_q;
    logic [WIDTH-1:0]   sum_d;
    logic               carry_q;
    logic               cout_q;
    logic               ovf_q;

    logic [SLICE_W-1:0] a_sl;
    logic [SLICE_W-1:0] b_sl;
    logic [SLICE_W-1:0] s_sl;
    logic [SLICE_W-1:0] c_sl;
    logic               last_slice;
    logic               low_carries_unused;

    // Select the active slice of each operand and merge the slice sum into the result.
    always_comb begin
        a_sl  = '0;
        b_sl  = '0;
        sum_d = sum_q;
        for (int i = 0; i < SLICES; i++) begin
            if (idx_q == IDX_W'(i)) begin
                a_sl                         = a_q[i*SLICE_W +: SLICE_W];
                b_sl                         = b_q[i*SLICE_W +: SLICE_W];
                sum_d[i*SLICE_W +: SLICE_W]  = s_sl;
            end
        end
    end

    assign last_slice         = (idx_q == IDX_W'(SLICES - 1));
    assign low_carries_unused = ^c_sl[SLICE_W-3:0];

    add7_slice u_slice (
        .a    (a_sl),
        .b    (b_sl),
        .c_in (carry_q),
        .s    (s_sl),
        .c    (c_sl)
    );

    // Subtraction is folded in at accept time: B is inverted and the carry seeded with 1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        a_q     <= in_a;
                        b_q     <= in_b ^ {WIDTH{in_sub}};
                        carry_q <= in_sub;
                        idx_q   <= '0;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    sum_q   <= sum_d;
                    carry_q <= c_sl[SLICE_W-1];
                    if (last_slice) begin
                        cout_q  <= c_sl[SLICE_W-1];
                        ovf_q   <= slice_ovf(c_sl[SLICE_W-1], c_sl[SLICE_W-2]);
                        state_q <= DONE;
                    end else begin
                        idx_q <= idx_q + IDX_W'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign out_sum   = sum_q;
    assign out_cout  = cout_q;
    assign out_ovf   = ovf_q;

endmodule

// File: tb/tb_add7_slice_sequencer.sv
// Bench for add7_slice_sequencer: a transaction-level reference model checked
// every cycle, plus directed cases with hand-computed expectations.
module tb_add7_slice_sequencer;

    localparam int SLICES = 4;
    localparam int WIDTH  = 28;
    localparam logic [WIDTH-1:0] MASK = '1;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] in_a = '0;
    logic [WIDTH-1:0] in_b = '0;
    logic             in_sub = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] out_sum;
    logic             out_cout;
    logic             out_ovf;
    logic             busy;

    int nChecks = 0;
    int nFails  = 0;

    bit               mBusy  = 1'b0;
    bit               mValid = 1'b0;
    int               mCount = 0;
    logic [WIDTH-1:0] expSum = '0;
    logic             expCout = 1'b0;
    logic             expOvf  = 1'b0;
    logic [WIDTH-1:0] lastSum = '0;
    logic             lastCout = 1'b0;
    logic             lastOvf  = 1'b0;

    always #5 clk = ~clk;

    add7_slice_sequencer #(.SLICES(SLICES)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_sub    (in_sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_cout  (out_cout),
        .out_ovf   (out_ovf),
        .busy      (busy)
    );

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        nChecks++;
        if (actual !== expected) begin
            nFails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Reference result from plain integer arithmetic on the full-width operands.
    task automatic computeRef(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                              input logic sub, output logic [WIDTH-1:0] sum,
                              output logic cout, output logic ovf);
        longint ua, ub, sa, sb, full, rs, half, range;
        ua    = longint'(a);
        ub    = longint'(b);
        half  = longint'(1) << (WIDTH - 1);
        range = longint'(1) << WIDTH;
        full  = sub ? (ua - ub) : (ua + ub);
        sum   = full[WIDTH-1:0];
        cout  = sub ? (ua >= ub) : (full >= range);
        sa    = (ua >= half) ? ua - range : ua;
        sb    = (ub >= half) ? ub - range : ub;
        rs    = sub ? (sa - sb) : (sa + sb);
        ovf   = (rs >= half) || (rs < -half);
    endtask

    // Protocol model: accept in idle, result due SLICES edges later, held until taken.
    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                mBusy    = 1'b0;
                mValid   = 1'b0;
                mCount   = 0;
                lastSum  = '0;
                lastCout = 1'b0;
                lastOvf  = 1'b0;
            end else if (mValid) begin
                if (out_ready) begin
                    mValid   = 1'b0;
                    mBusy    = 1'b0;
                    lastSum  = expSum;
                    lastCout = expCout;
                    lastOvf  = expOvf;
                end
            end else if (mBusy) begin
                mCount++;
                if (mCount == SLICES) mValid = 1'b1;
            end else if (in_valid) begin
                mBusy  = 1'b1;
                mCount = 0;
                computeRef(in_a, in_b, in_sub, expSum, expCout, expOvf);
            end
        end
    end

    // Per-cycle comparison of every meaningful output against the model.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                checkOutput("rst_out_valid", out_valid, 1'b0);
                checkOutput("rst_busy", busy, 1'b0);
                checkOutput("rst_in_ready", in_ready, 1'b1);
                checkOutput("rst_out_sum", out_sum, '0);
            end else begin
                checkOutput("mon_out_valid", out_valid, mValid);
                checkOutput("mon_in_ready", in_ready, !mBusy);
                checkOutput("mon_busy", busy, mBusy);
                if (mValid) begin
                    checkOutput("mon_sum", out_sum, expSum);
                    checkOutput("mon_cout", out_cout, expCout);
                    checkOutput("mon_ovf", out_ovf, expOvf);
                end else if (!mBusy) begin
                    checkOutput("mon_held_sum", out_sum, lastSum);
                    checkOutput("mon_held_cout", out_cout, lastCout);
                    checkOutput("mon_held_ovf", out_ovf, lastOvf);
                end
            end
        end
    end

    // Present a request, wait (bounded) for acceptance, then scramble the inputs.
    task automatic applyStimulus(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                 input logic sub);
        int guard;
        in_a     = a;
        in_b     = b;
        in_sub   = sub;
        in_valid = 1'b1;
        guard    = 0;
        while (!in_ready && guard < 50) begin
            @(posedge clk);
            #1;
            guard++;
        end
        if (!in_ready) checkOutput("accept_wait", in_ready, 1'b1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_a     = WIDTH'($urandom);
        in_b     = WIDTH'($urandom);
        in_sub   = 1'($urandom);
    endtask

    task automatic waitResult(output int edges);
        edges = 0;
        while (!out_valid && edges < 50) begin
            @(posedge clk);
            #1;
            edges++;
        end
    endtask

    task automatic releaseResult(input string name);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        checkOutput({name, "_drop_valid"}, out_valid, 1'b0);
        checkOutput({name, "_idle_ready"}, in_ready, 1'b1);
    endtask

    task automatic runOp(input string name, input logic [WIDTH-1:0] a,
                         input logic [WIDTH-1:0] b, input logic sub,
                         input logic [WIDTH-1:0] wantSum, input logic wantCout,
                         input logic wantOvf);
        int edges;
        applyStimulus(a, b, sub);
        waitResult(edges);
        checkOutput({name, "_latency"}, edges, SLICES);
        checkOutput({name, "_sum"}, out_sum, wantSum);
        checkOutput({name, "_cout"}, out_cout, wantCout);
        checkOutput({name, "_ovf"}, out_ovf, wantOvf);
        releaseResult(name);
    endtask

    function automatic logic [WIDTH-1:0] pickOperand();
        case ($urandom_range(0, 5))
            0:       return '0;
            1:       return MASK;
            2:       return 28'h7FF_FFFF;
            3:       return 28'h800_0000;
            default: return WIDTH'($urandom);
        endcase
    endfunction

    initial begin
        int edges;
        @(posedge clk);
        #1;
        checkOutput("reset_in_ready", in_ready, 1'b1);
        checkOutput("reset_out_valid", out_valid, 1'b0);
        checkOutput("reset_busy", busy, 1'b0);
        checkOutput("reset_out_sum", out_sum, '0);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;

        runOp("carry_chain", 28'hFFF_FFFF, 28'h000_0001, 1'b0, 28'h000_0000, 1'b1, 1'b0);
        runOp("sub_borrow",  28'h000_0005, 28'h000_0007, 1'b1, 28'hFFF_FFFE, 1'b0, 1'b0);
        runOp("ovf_add",     28'h7FF_FFFF, 28'h000_0001, 1'b0, 28'h800_0000, 1'b0, 1'b1);
        runOp("ovf_sub",     28'h800_0000, 28'h000_0001, 1'b1, 28'h7FF_FFFF, 1'b1, 1'b1);
        runOp("slice_edge",  28'h000_007F, 28'h000_0001, 1'b0, 28'h000_0080, 1'b0, 1'b0);

        applyStimulus(28'h000_1000, 28'h000_2000, 1'b0);
        waitResult(edges);
        checkOutput("bp_latency", edges, SLICES);
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'(i % 2);
            in_a     = WIDTH'($urandom);
            in_b     = WIDTH'($urandom);
            in_sub   = 1'($urandom);
            @(posedge clk);
            #1;
            checkOutput("bp_out_valid", out_valid, 1'b1);
            checkOutput("bp_in_ready", in_ready, 1'b0);
            checkOutput("bp_sum", out_sum, 28'h000_3000);
        end
        in_valid = 1'b0;
        releaseResult("bp");
        runOp("after_bp", 28'h000_0123, 28'h000_0456, 1'b0, 28'h000_0579, 1'b0, 1'b0);

        applyStimulus(28'h123_4567, 28'h000_0001, 1'b0);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("midrst_out_valid", out_valid, 1'b0);
        checkOutput("midrst_busy", busy, 1'b0);
        checkOutput("midrst_out_sum", out_sum, '0);
        checkOutput("midrst_in_ready", in_ready, 1'b1);
        @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;
        runOp("post_reset", 28'h000_0010, 28'h000_0020, 1'b0, 28'h000_0030, 1'b0, 1'b0);

        for (int i = 0; i < 400; i++) begin
            in_valid  = 1'($urandom);
            in_a      = pickOperand();
            in_b      = pickOperand();
            in_sub    = 1'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            @(posedge clk);
            #1;
        end

        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (SLICES + 4) begin
            @(posedge clk);
            #1;
        end
        checkOutput("drain_idle", in_ready, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", nChecks, nFails);
        $finish;
    end

endmodule
